// File: rtl/merge.sv
// -----------------------------------------------------------------------------
// merge : N-to-1 native-bus merger with round-robin arbitration.
//
// Lets N_MASTERS masters share one slave port. In IDLE the arbiter picks the
// first valid master starting at the round-robin pointer. It then moves to
// BUSY and holds that grant until the slave returns ready. The datapath is
// combinational from the registered state and grant, so the slave sees the
// request one cycle after the master raises valid. The slave never sees a
// request in the cycle after ready.
//
// Bus packing (per port):
//   request  = {valid, addr[ADDR_W], wdata[DATA_W], wstrb[DATA_W/8]}, valid is MSB
//   response = {rdata[DATA_W], ready}, ready is LSB
//   master i occupies m_req[i*REQ_W +: REQ_W] and m_resp[i*RESP_W +: RESP_W]
//
// Ports:
//   clk     in   1                  clock, rising edge
//   rst     in   1                  asynchronous, active-high reset
//   m_req   in   N_MASTERS*REQ_W    master requests
//   m_resp  out  N_MASTERS*RESP_W   master responses (only granted port live)
//   s_req   out  REQ_W              request to the shared slave
//   s_resp  in   RESP_W             response from the shared slave
//   m_grant out  N_MASTERS          one-hot current grant, 0 when idle
// -----------------------------------------------------------------------------
module merge #(
    parameter  int N_MASTERS = 2,
    parameter  int ADDR_W    = 16,
    parameter  int DATA_W    = 16,
    localparam int STRB_W    = DATA_W / 8,
    localparam int REQ_W     = 1 + ADDR_W + DATA_W + STRB_W,
    localparam int RESP_W    = DATA_W + 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_MASTERS*REQ_W-1:0]    m_req,
    output logic [N_MASTERS*RESP_W-1:0]   m_resp,
    output logic [REQ_W-1:0]              s_req,
    input  logic [RESP_W-1:0]             s_resp,
    output logic [N_MASTERS-1:0]          m_grant
);

    localparam int SEL_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_MASTERS - 1);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [SEL_W-1:0] gsel_r;
    logic [SEL_W-1:0] gsel_next_s;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] ptr_next_s;
    logic [N_MASTERS-1:0] m_valid_s;
    logic             any_valid_s;
    logic             s_ready_s;

    // Index after idx, wrapping explicitly so non-power-of-two N works.
    function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
        logic [SEL_W-1:0] nxt;
        if (idx == LAST_IDX) begin
            nxt = '0;
        end else begin
            nxt = idx + SEL_W'(1);
        end
        return nxt;
    endfunction

    // First valid index searching start, start+1, ... modulo N_MASTERS.
    // Duplicating the valid vector and shifting by start turns the
    // wrapping search into a plain low-to-high scan.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_MASTERS-1:0] valid,
                                                 input logic [SEL_W-1:0]     start);
        logic [2*N_MASTERS-1:0] rotated;
        logic [SEL_W:0]         sum;
        logic [SEL_W-1:0]       pick;
        logic                   found;
        rotated = {valid, valid} >> start;
        sum     = '0;
        pick    = start;
        found   = 1'b0;
        for (int k = 0; k < N_MASTERS; k++) begin
            if (!found && rotated[k]) begin
                sum = {1'b0, start} + (SEL_W+1)'(k);
                if (sum >= (SEL_W+1)'(N_MASTERS)) begin
                    sum = sum - (SEL_W+1)'(N_MASTERS);
                end else begin
                    sum = sum;
                end
                pick  = sum[SEL_W-1:0];
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Gather the valid bit (MSB) of every master request.
    always_comb begin
        m_valid_s = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid_s[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    assign any_valid_s = |m_valid_s;
    assign s_ready_s   = s_resp[0];

    // Next-state logic: arbitrate in IDLE, wait for ready in BUSY.
    always_comb begin
        state_next_s = state_r;
        gsel_next_s  = gsel_r;
        ptr_next_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (any_valid_s) begin
                    state_next_s = BUSY;
                    gsel_next_s  = rr_pick(m_valid_s, ptr_r);
                end else begin
                    state_next_s = IDLE;
                end
            end
            BUSY: begin
                // Grant is held even if the master drops valid early.
                if (s_ready_s) begin
                    state_next_s = IDLE;
                    ptr_next_s   = next_idx(gsel_r);
                end else begin
                    state_next_s = BUSY;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            gsel_r  <= '0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            gsel_r  <= gsel_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    // Route the granted master to the slave and the slave response back.
    // Everything is zero in IDLE, so a stray ready there goes nowhere.
    always_comb begin
        s_req   = '0;
        m_resp  = '0;
        m_grant = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if ((state_r == BUSY) && (gsel_r == SEL_W'(i))) begin
                s_req                        = m_req[i*REQ_W +: REQ_W];
                m_resp[i*RESP_W +: RESP_W]   = s_resp;
                m_grant[i]                   = 1'b1;
            end else begin
                m_grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_merge.sv
// -----------------------------------------------------------------------------
// tb_merge : directed self-checking bench for merge.
// A 2-master instance covers single access, contention, wait states, reset
// and stray ready; a 3-master instance covers round-robin wrap-around.
// -----------------------------------------------------------------------------
module tb_merge;

    localparam int REQ_W  = 35;
    localparam int RESP_W = 17;

    logic                 clk;
    logic                 rst;

    logic [2*REQ_W-1:0]   m_req2;
    logic [2*RESP_W-1:0]  m_resp2;
    logic [REQ_W-1:0]     s_req2;
    logic [RESP_W-1:0]    s_resp2;
    logic [1:0]           m_grant2;

    logic [3*REQ_W-1:0]   m_req3;
    logic [3*RESP_W-1:0]  m_resp3;
    logic [REQ_W-1:0]     s_req3;
    logic [RESP_W-1:0]    s_resp3;
    logic [2:0]           m_grant3;

    int checks;
    int errors;

    logic [REQ_W-1:0] req_a, req_b, req_d, req_e;
    logic [REQ_W-1:0] r3_m0, r3_m1, r3_m2;
    logic [REQ_W-1:0] exp_req;
    logic [1:0]       exp_g [7] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00};

    merge #(.N_MASTERS(2), .ADDR_W(16), .DATA_W(16)) u_dut2 (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req2),
        .m_resp  (m_resp2),
        .s_req   (s_req2),
        .s_resp  (s_resp2),
        .m_grant (m_grant2)
    );

    merge #(.N_MASTERS(3), .ADDR_W(16), .DATA_W(16)) u_dut3 (
        .clk     (clk),
        .rst     (rst),
        .m_req   (m_req3),
        .m_resp  (m_resp3),
        .s_req   (s_req3),
        .s_resp  (s_resp3),
        .m_grant (m_grant3)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case the sequence ever stalls.
    initial begin
        #100000;
        $display("FAIL timeout sim time exceeded, got running required finished");
        $fatal(1, "timeout");
    end

    function automatic logic [REQ_W-1:0] mk_req(input logic v, input logic [15:0] a,
                                                 input logic [15:0] d, input logic [1:0] s);
        return {v, a, d, s};
    endfunction

    function automatic logic [RESP_W-1:0] mk_resp(input logic [15:0] d, input logic rdy);
        return {d, rdy};
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        rst     = 1'b1;
        m_req2  = '0;
        s_resp2 = '0;
        m_req3  = '0;
        s_resp3 = '0;
        req_a = mk_req(1'b1, 16'h0010, 16'h0000, 2'b00);
        req_b = mk_req(1'b1, 16'h0030, 16'h0000, 2'b00);
        req_d = mk_req(1'b1, 16'h0040, 16'h1234, 2'b11);
        req_e = mk_req(1'b1, 16'h0050, 16'h0000, 2'b00);
        r3_m0 = mk_req(1'b1, 16'h0200, 16'h0000, 2'b00);
        r3_m1 = mk_req(1'b1, 16'h0101, 16'h0000, 2'b00);
        r3_m2 = mk_req(1'b1, 16'h0202, 16'h0000, 2'b00);

        // Reset state.
        repeat (2) step();
        #1;
        check_eq("rst_sreq2",  s_req2,   '0);
        check_eq("rst_mresp2", m_resp2,  '0);
        check_eq("rst_grant2", m_grant2, 2'b00);
        check_eq("rst_sreq3",  s_req3,   '0);
        check_eq("rst_mresp3", m_resp3,  '0);
        check_eq("rst_grant3", m_grant3, 3'b000);
        rst = 1'b0;

        // 1: single master read, ready one cycle after forwarding.
        step();
        m_req2 = {{REQ_W{1'b0}}, req_a};
        #1;
        check_eq("t1_not_yet", s_req2, '0);
        step();
        #1;
        check_eq("t1_sreq",  s_req2,   req_a);
        check_eq("t1_grant", m_grant2, 2'b01);
        check_eq("t1_wait",  m_resp2,  '0);
        step();
        s_resp2 = mk_resp(16'hCAFE, 1'b1);
        #1;
        check_eq("t1_resp", m_resp2, {{RESP_W{1'b0}}, mk_resp(16'hCAFE, 1'b1)});
        step();
        m_req2  = '0;
        s_resp2 = '0;
        #1;
        check_eq("t1_idle_sreq",  s_req2,   '0);
        check_eq("t1_idle_grant", m_grant2, 2'b00);

        // 2: contention from reset, both held, slave always ready.
        rst = 1'b1;
        #1;
        rst = 1'b0;
        m_req2  = {req_b, req_a};
        s_resp2 = mk_resp(16'h0000, 1'b1);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) step();
            #1;
            check_eq("t2_grant", m_grant2, exp_g[i]);
            exp_req = (exp_g[i] == 2'b01) ? req_a : ((exp_g[i] == 2'b10) ? req_b : '0);
            check_eq("t2_sreq", s_req2, exp_req);
        end
        m_req2  = '0;
        s_resp2 = '0;

        // 3: three masters, ptr moved to 2, then m2 and m0 requesting.
        m_req3  = {{REQ_W{1'b0}}, r3_m1, {REQ_W{1'b0}}};
        s_resp3 = mk_resp(16'h0000, 1'b1);
        step();
        #1;
        check_eq("t3_m1", m_grant3, 3'b010);
        step();
        m_req3 = {r3_m2, {REQ_W{1'b0}}, r3_m0};
        #1;
        check_eq("t3_idle0", m_grant3, 3'b000);
        step();
        #1;
        check_eq("t3_m2",      m_grant3, 3'b100);
        check_eq("t3_m2_sreq", s_req3,   r3_m2);
        step();
        #1;
        check_eq("t3_idle1", m_grant3, 3'b000);
        step();
        #1;
        check_eq("t3_m0_wrap", m_grant3, 3'b001);
        check_eq("t3_m0_sreq", s_req3,   r3_m0);
        step();
        m_req3 = {{REQ_W{1'b0}}, r3_m1, r3_m0};
        #1;
        check_eq("t3_idle2", m_grant3, 3'b000);
        step();
        #1;
        check_eq("t3_ptr_is_1", m_grant3, 3'b010);
        step();
        m_req3  = '0;
        s_resp3 = '0;

        // 4: five wait states on m1, then ready; valid gone the next cycle.
        m_req2  = {req_d, {REQ_W{1'b0}}};
        s_resp2 = '0;
        step();
        for (int i = 0; i < 5; i++) begin
            #1;
            check_eq("t4_sreq_held", s_req2,   req_d);
            check_eq("t4_grant",     m_grant2, 2'b10);
            check_eq("t4_no_resp",   m_resp2,  '0);
            step();
        end
        s_resp2 = mk_resp(16'hBEEF, 1'b1);
        #1;
        check_eq("t4_resp",  m_resp2,  {mk_resp(16'hBEEF, 1'b1), {RESP_W{1'b0}}});
        check_eq("t4_grant_rdy", m_grant2, 2'b10);
        step();
        #1;
        check_eq("t4_no_dup", s_req2,   '0);
        check_eq("t4_idle",   m_grant2, 2'b00);
        m_req2  = '0;
        s_resp2 = '0;

        // 5: asynchronous reset in the middle of a wait state.
        step();
        m_req2  = {req_e, {REQ_W{1'b0}}};
        s_resp2 = mk_resp(16'h7777, 1'b0);
        step();
        #1;
        check_eq("t5_busy",   m_grant2, 2'b10);
        check_eq("t5_live",   m_resp2,  {mk_resp(16'h7777, 1'b0), {RESP_W{1'b0}}});
        rst = 1'b1;
        #1;
        check_eq("t5_rst_sreq",  s_req2,   '0);
        check_eq("t5_rst_mresp", m_resp2,  '0);
        check_eq("t5_rst_grant", m_grant2, 2'b00);
        rst = 1'b0;
        step();
        #1;
        check_eq("t5_regrant", m_grant2, 2'b10);
        check_eq("t5_sreq",    s_req2,   req_e);
        s_resp2 = mk_resp(16'h0000, 1'b1);
        step();
        m_req2  = '0;
        s_resp2 = '0;

        // 6: stray ready while idle goes nowhere and does not change state.
        s_resp2 = mk_resp(16'h5555, 1'b1);
        #1;
        check_eq("t6_mresp",  m_resp2,  '0);
        check_eq("t6_grant",  m_grant2, 2'b00);
        step();
        #1;
        check_eq("t6_mresp2", m_resp2,  '0);
        check_eq("t6_grant2", m_grant2, 2'b00);
        m_req2 = {{REQ_W{1'b0}}, req_a};
        #1;
        check_eq("t6_still_idle", s_req2, '0);
        step();
        #1;
        check_eq("t6_served", m_resp2, {{RESP_W{1'b0}}, mk_resp(16'h5555, 1'b1)});
        step();
        m_req2  = '0;
        s_resp2 = '0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
